// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory port arbiter.
// slave = arbiter view, master = pipeline/memory-model view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stall_f;
  logic          stall_m;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, stall_f, stall_m,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, stall_f, stall_m,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (I) and mem stage (D); D has priority,
// a starvation counter forces an I grant after STARVE_MAX contested D grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [3:0]    WAIT_LOAD  = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic          own_i;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        r_state;
  logic          r_own_i;
  logic          r_we;
  logic [3:0]    r_wcnt;
  logic [SW-1:0] r_starve;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_i_ack;
  logic          r_d_ack;

  logic          w_any;
  logic          w_grant_i;
  req_t          w_req;

  assign w_any     = bus.i_req | bus.d_req;
  assign w_grant_i = bus.i_req & (~bus.d_req | (r_starve == STARVE_TOP));

  always_comb begin
    w_req = '0;
    if (w_grant_i) begin
      w_req.own_i = 1'b1;
      w_req.addr  = bus.i_addr;
    end else begin
      w_req.we    = bus.d_we;
      w_req.addr  = bus.d_addr;
      w_req.wdata = bus.d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_own_i     <= 1'b0;
      r_we        <= 1'b0;
      r_wcnt      <= '0;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_own_i     <= w_req.own_i;
          r_we        <= w_req.we;
          r_mem_addr  <= w_req.addr;
          r_mem_wdata <= w_req.wdata;
          r_mem_en    <= 1'b1;
          r_mem_we    <= w_req.we;
          // Only contested D grants count toward forcing fetch through
          if (w_grant_i)
            r_starve <= '0;
          else if (bus.i_req && r_starve != STARVE_TOP)
            r_starve <= r_starve + 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_wcnt   <= WAIT_LOAD;
          r_state  <= S_WAIT;
        end
        S_WAIT: if (r_wcnt == '0) begin
          if (r_own_i) begin
            r_i_rdata <= bus.mem_rdata;
            r_i_ack   <= 1'b1;
          end else begin
            r_d_rdata <= r_we ? '0 : bus.mem_rdata;
            r_d_ack   <= 1'b1;
          end
          r_state <= S_RESP;
        end else begin
          r_wcnt <= r_wcnt - 1'b1;
        end
        S_RESP: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.stall_f   = bus.i_req & ~r_i_ack;
  assign bus.stall_m   = bus.d_req & ~r_d_ack;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level arbitration model; memory is a fixed-latency array.
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: data valid only in the cycle MEM_LAT after mem_en, noise otherwise
  int          cyc = 0;
  bit          pend_v = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] mem [16];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 4) ? 32'hE3A0_0005 : (32'hA500_0000 | 32'(i));
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      pend_v    <= 1'b1;
      pend_due  <= cyc + MEM_LAT;
      pend_data <= mem[bus.mem_addr[5:2]];
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) bus.mem_rdata = (pend_v && pend_due == cyc) ? pend_data : $urandom;

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_en, bus.mem_we, bus.i_ack, bus.d_ack, bus.stall_f, bus.stall_m} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_ctl cyc %0d got %b exp 000000", k,
                 {bus.mem_en, bus.mem_we, bus.i_ack, bus.d_ack, bus.stall_f, bus.stall_m});
      end
      vectors++;
      if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'b0) begin
        miscompares++;
        $display("FAIL reset_data got %h %h %h %h exp zeros", bus.mem_addr, bus.mem_wdata,
                 bus.i_rdata, bus.d_rdata);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    int st = 0;
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    #1 if (bus.stall_f) st++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_en, bus.i_ack, bus.d_ack} !== {k == 1, k == 4, 1'b0}) begin
        miscompares++;
        $display("FAIL fetch_seq k %0d got en/ia/da %b exp %b", k,
                 {bus.mem_en, bus.i_ack, bus.d_ack}, {k == 1, k == 4, 1'b0});
      end
      if (k == 1) begin
        vectors++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h10}) begin
          miscompares++;
          $display("FAIL fetch_addr got we %b addr %h exp 0 00000010", bus.mem_we, bus.mem_addr);
        end
      end
      if (k == 4) begin
        vectors++;
        if (bus.i_rdata !== 32'hE3A0_0005) begin
          miscompares++;
          $display("FAIL fetch_data got %h exp e3a00005", bus.i_rdata);
        end
        bus.i_req = 1'b0;
      end
      #1 if (bus.stall_f) st++;
    end
    vectors++;
    if (st != 4) begin
      miscompares++;
      $display("FAIL fetch_stall got %0d cycles exp 4", st);
    end
  endtask

  task automatic test_write();
    bus.d_addr  = 32'd20;
    bus.d_wdata = 32'd7;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_en, bus.i_ack, bus.d_ack} !== {k == 1, 1'b0, k == 4}) begin
        miscompares++;
        $display("FAIL write_seq k %0d got en/ia/da %b exp %b", k,
                 {bus.mem_en, bus.i_ack, bus.d_ack}, {k == 1, 1'b0, k == 4});
      end
      if (k == 1) begin
        vectors++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd20, 32'd7}) begin
          miscompares++;
          $display("FAIL write_bus got we %b addr %0d wdata %0d exp 1 20 7", bus.mem_we,
                   bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == 4) begin
        vectors++;
        if (bus.d_rdata !== 32'd0) begin
          miscompares++;
          $display("FAIL write_rdata got %h exp 0", bus.d_rdata);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
    end
  endtask

  task automatic test_both();
    bus.i_addr = 32'h14;
    bus.d_addr = 32'h10;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_en, bus.i_ack, bus.d_ack} !== {k == 1 || k == 6, k == 9, k == 4}) begin
        miscompares++;
        $display("FAIL both_seq k %0d got en/ia/da %b exp %b", k,
                 {bus.mem_en, bus.i_ack, bus.d_ack}, {k == 1 || k == 6, k == 9, k == 4});
      end
      if (k == 1 || k == 6) begin
        vectors++;
        if (bus.mem_addr !== ((k == 1) ? 32'h10 : 32'h14)) begin
          miscompares++;
          $display("FAIL both_addr k %0d got %h", k, bus.mem_addr);
        end
      end
      if (k == 4) begin
        vectors++;
        if (bus.d_rdata !== 32'hE3A0_0005) begin
          miscompares++;
          $display("FAIL both_ddata got %h exp e3a00005", bus.d_rdata);
        end
        bus.d_req = 1'b0;
      end
      if (k == 9) begin
        vectors++;
        if (bus.i_rdata !== 32'd7) begin
          miscompares++;
          $display("FAIL both_idata got %h exp 7", bus.i_rdata);
        end
        bus.i_req = 1'b0;
      end
    end
  endtask

  task automatic test_starve();
    int nd = 0;
    bit got_i = 1'b0, first_d = 1'b0, got_d = 1'b0, got_i2 = 1'b0;
    bus.i_addr = 32'h10;
    bus.d_addr = 32'h14;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 0; k < 60 && !got_i; k++) begin
      @(negedge clk);
      if (bus.d_ack) nd++;
      if (bus.i_ack) got_i = 1'b1;
    end
    vectors++;
    if (!got_i || nd != STARVE_MAX) begin
      miscompares++;
      $display("FAIL starve_count got i_ack %0d after %0d d grants exp 1 after %0d", got_i, nd,
               STARVE_MAX);
    end
    // Both still requesting: a cleared counter must hand the next grant back to D
    for (int k = 0; k < 30 && !got_i2; k++) begin
      @(negedge clk);
      if (bus.d_ack && !got_d) begin
        got_d = 1'b1;
        first_d = 1'b1;
        bus.d_req = 1'b0;
      end
      if (bus.i_ack) begin
        got_i2 = 1'b1;
        bus.i_req = 1'b0;
      end
    end
    vectors++;
    if (!(first_d && got_i2)) begin
      miscompares++;
      $display("FAIL starve_clear got d_first %0d i_done %0d exp 1 1", first_d, got_i2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.i_addr = 32'h14;
    bus.i_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    bus.i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.i_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_rdata got %h exp 0", bus.i_rdata);
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if ({bus.mem_en, bus.i_ack, bus.d_ack} !== 3'b0) begin
        miscompares++;
        $display("FAIL rstmid_quiet k %0d got en/ia/da %b exp 000", k,
                 {bus.mem_en, bus.i_ack, bus.d_ack});
      end
    end
    bus.d_addr = 32'h14;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_en, bus.d_ack} !== {k == 1, k == 4}) begin
        miscompares++;
        $display("FAIL rstmid_next k %0d got en/da %b exp %b", k, {bus.mem_en, bus.d_ack},
                 {k == 1, k == 4});
      end
      if (k == 4) begin
        vectors++;
        if (bus.d_rdata !== 32'd7) begin
          miscompares++;
          $display("FAIL rstmid_data got %h exp 7", bus.d_rdata);
        end
        bus.d_req = 1'b0;
      end
    end
  endtask

  // Transaction-level model: when free, pick a winner by the priority/starvation rule,
  // expect mem_en one cycle later and the ack MEM_LAT+2 cycles after the grant cycle.
  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] t_addr = '0, t_wd = '0, t_data = '0;
    bit act = 1'b0, t_i = 1'b0, t_we = 1'b0, ireq = 1'b0, dreq = 1'b0;
    bit e_men, e_ia, e_da, gi;
    int t_iss = 0, t_ack = 0, free = 0, starve = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 4) ? 32'hE3A0_0005 : (32'hA500_0000 | 32'(i));
    ref_mem[5] = 32'd7;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e_men = act && c == t_iss;
      e_ia  = act && t_i && c == t_ack;
      e_da  = act && !t_i && c == t_ack;
      vectors++;
      if ({bus.mem_en, bus.i_ack, bus.d_ack} !== {e_men, e_ia, e_da}) begin
        miscompares++;
        $display("FAIL rnd_seq c %0d got en/ia/da %b exp %b", c, {bus.mem_en, bus.i_ack, bus.d_ack},
                 {e_men, e_ia, e_da});
      end
      if (e_men) begin
        vectors++;
        if ({bus.mem_we, bus.mem_addr} !== {t_we, t_addr} || (t_we && bus.mem_wdata !== t_wd)) begin
          miscompares++;
          $display("FAIL rnd_bus c %0d got we %b addr %h wd %h exp %b %h %h", c, bus.mem_we,
                   bus.mem_addr, bus.mem_wdata, t_we, t_addr, t_wd);
        end
      end
      if (e_ia || e_da) begin
        vectors++;
        if ((e_ia ? bus.i_rdata : bus.d_rdata) !== t_data) begin
          miscompares++;
          $display("FAIL rnd_data c %0d side %s got %h exp %h", c, e_ia ? "I" : "D",
                   e_ia ? bus.i_rdata : bus.d_rdata, t_data);
        end
        act  = 1'b0;
        free = c + 1;
        if (t_i) ireq = 1'b0; else dreq = 1'b0;
      end
      if (!ireq && c < 380 && $urandom_range(0, 2) == 0) begin
        ireq       = 1'b1;
        bus.i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dreq && c < 380 && $urandom_range(0, 2) == 0) begin
        dreq        = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = 32'($urandom_range(0, 15)) << 2;
        bus.d_wdata = $urandom;
      end
      bus.i_req = ireq;
      bus.d_req = dreq;
      #1;
      vectors++;
      if ({bus.stall_f, bus.stall_m} !== {ireq & ~e_ia, dreq & ~e_da}) begin
        miscompares++;
        $display("FAIL rnd_stall c %0d got %b exp %b", c, {bus.stall_f, bus.stall_m},
                 {ireq & ~e_ia, dreq & ~e_da});
      end
      if (!act && c >= free && (ireq || dreq)) begin
        gi = ireq && (!dreq || starve == STARVE_MAX);
        if (gi) starve = 0;
        else if (ireq && starve < STARVE_MAX) starve++;
        t_i    = gi;
        t_we   = gi ? 1'b0 : bus.d_we;
        t_addr = gi ? bus.i_addr : bus.d_addr;
        t_wd   = bus.d_wdata;
        if (t_we) begin
          ref_mem[t_addr[5:2]] = t_wd;
          t_data = '0;
        end else begin
          t_data = ref_mem[t_addr[5:2]];
        end
        t_iss = c + 1;
        t_ack = c + 2 + MEM_LAT;
        act   = 1'b1;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    test_reset();
    test_fetch();
    test_write();
    test_both();
    test_starve();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
